l1_mem_arbiter: RTL and testbench

- Shares the single L1-to-memory request port between the Icache miss FSM and the Dcache miss/writeback FSM.
- Captures the winning request and drives the downstream memory handshake (req/addrOK/dataOK).
- Steers addrOK, dataOK and read data back to the granted cache only.
- Sits between both L1 caches and the memory/AXI bridge. At most one transaction is outstanding.

---
 rtl/l1_mem_arbiter_if.sv | 48 ++++
 rtl/l1_mem_arbiter.sv | 96 +++++++++
 tb/tb_l1_mem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_arbiter_if.sv
// Handshake bundle between the two L1 miss engines, the arbiter and the memory bridge.
// The slave modport is the arbiter's view; master is the surrounding caches plus memory.
interface l1_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  icache_mem_req;
    logic [31:0]           icache_mem_addr;
    logic [1:0]            icache_mem_size;
    logic                  mem_icache_addrOK;
    logic                  mem_icache_dataOK;
    logic [DATA_WIDTH-1:0] mem_icache_rdata;

    logic                  dcache_mem_req;
    logic                  dcache_mem_wr;
    logic [31:0]           dcache_mem_addr;
    logic [1:0]            dcache_mem_size;
    logic [DATA_WIDTH-1:0] dcache_mem_wdata;
    logic                  mem_dcache_addrOK;
    logic                  mem_dcache_dataOK;
    logic [DATA_WIDTH-1:0] mem_dcache_rdata;

    logic                  arb_mem_req;
    logic                  arb_mem_wr;
    logic [31:0]           arb_mem_addr;
    logic [1:0]            arb_mem_size;
    logic [DATA_WIDTH-1:0] arb_mem_wdata;
    logic                  mem_arb_addrOK;
    logic                  mem_arb_dataOK;
    logic [DATA_WIDTH-1:0] mem_arb_rdata;

    modport slave (
        input  icache_mem_req, icache_mem_addr, icache_mem_size,
        output mem_icache_addrOK, mem_icache_dataOK, mem_icache_rdata,
        input  dcache_mem_req, dcache_mem_wr, dcache_mem_addr, dcache_mem_size, dcache_mem_wdata,
        output mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_rdata,
        output arb_mem_req, arb_mem_wr, arb_mem_addr, arb_mem_size, arb_mem_wdata,
        input  mem_arb_addrOK, mem_arb_dataOK, mem_arb_rdata
    );

    modport master (
        output icache_mem_req, icache_mem_addr, icache_mem_size,
        input  mem_icache_addrOK, mem_icache_dataOK, mem_icache_rdata,
        output dcache_mem_req, dcache_mem_wr, dcache_mem_addr, dcache_mem_size, dcache_mem_wdata,
        input  mem_dcache_addrOK, mem_dcache_dataOK, mem_dcache_rdata,
        input  arb_mem_req, arb_mem_wr, arb_mem_addr, arb_mem_size, arb_mem_wdata,
        output mem_arb_addrOK, mem_arb_dataOK, mem_arb_rdata
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// Single-outstanding arbiter sharing the L1 memory port between Icache and Dcache.
// Define L1_ARB_RR_EN for round-robin on simultaneous requests; default is Dcache priority.
module l1_mem_arbiter #(
    parameter int data_width = 32
) (
    input  logic            clk,
    input  logic            rst,
    l1_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } state_e;

    state_e                state_q;
    logic                  owner_q;
    logic                  hold_wr_q;
    logic [31:0]           hold_addr_q;
    logic [1:0]            hold_size_q;
    logic [data_width-1:0] hold_wdata_q;

    logic any_req;
    logic pick_dcache;
    logic addr_ack;
    logic data_ack;

    assign any_req = bus.icache_mem_req | bus.dcache_mem_req;

`ifdef L1_ARB_RR_EN
    logic last_owner_q;
    // On a tie the cache that did not win last time gets the port.
    assign pick_dcache = bus.dcache_mem_req & (~bus.icache_mem_req | ~last_owner_q);
`else
    assign pick_dcache = bus.dcache_mem_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            hold_wr_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_size_q  <= '0;
            hold_wdata_q <= '0;
`ifdef L1_ARB_RR_EN
            last_owner_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q      <= ISSUE;
                        owner_q      <= pick_dcache;
                        hold_wr_q    <= pick_dcache & bus.dcache_mem_wr;
                        hold_addr_q  <= pick_dcache ? bus.dcache_mem_addr : bus.icache_mem_addr;
                        hold_size_q  <= pick_dcache ? bus.dcache_mem_size : bus.icache_mem_size;
                        hold_wdata_q <= pick_dcache ? bus.dcache_mem_wdata : '0;
`ifdef L1_ARB_RR_EN
                        last_owner_q <= pick_dcache;
`endif
                    end
                end
                ISSUE: begin
                    // A same-cycle dataOK completes the beat without visiting WAIT_DATA.
                    if (bus.mem_arb_addrOK)
                        state_q <= bus.mem_arb_dataOK ? IDLE : WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (bus.mem_arb_dataOK)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are masked while rst is high so an abandoned beat never reaches a cache.
    assign addr_ack = ~rst & (state_q == ISSUE) & bus.mem_arb_addrOK;
    assign data_ack = ~rst & bus.mem_arb_dataOK &
                      (((state_q == ISSUE) & bus.mem_arb_addrOK) | (state_q == WAIT_DATA));

    assign bus.arb_mem_req   = ~rst & (state_q == ISSUE);
    assign bus.arb_mem_wr    = hold_wr_q;
    assign bus.arb_mem_addr  = hold_addr_q;
    assign bus.arb_mem_size  = hold_size_q;
    assign bus.arb_mem_wdata = hold_wdata_q;

    assign bus.mem_icache_addrOK = addr_ack & ~owner_q;
    assign bus.mem_icache_dataOK = data_ack & ~owner_q;
    assign bus.mem_dcache_addrOK = addr_ack &  owner_q;
    assign bus.mem_dcache_dataOK = data_ack &  owner_q;

    assign bus.mem_icache_rdata = bus.mem_arb_rdata;
    assign bus.mem_dcache_rdata = bus.mem_arb_rdata;
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Directed scenarios followed by a randomized run against a transaction-level model.
module tb_l1_mem_arbiter;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    l1_mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();
    l1_mem_arbiter #(.data_width(DW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clr_in();
        bus.icache_mem_req   = 1'b0;
        bus.icache_mem_addr  = '0;
        bus.icache_mem_size  = '0;
        bus.dcache_mem_req   = 1'b0;
        bus.dcache_mem_wr    = 1'b0;
        bus.dcache_mem_addr  = '0;
        bus.dcache_mem_size  = '0;
        bus.dcache_mem_wdata = '0;
        bus.mem_arb_addrOK   = 1'b0;
        bus.mem_arb_dataOK   = 1'b0;
        bus.mem_arb_rdata    = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    // {arb_mem_req, icache addrOK, icache dataOK, dcache addrOK, dcache dataOK}
    function automatic logic [4:0] strobes();
        return {bus.arb_mem_req, bus.mem_icache_addrOK, bus.mem_icache_dataOK,
                bus.mem_dcache_addrOK, bus.mem_dcache_dataOK};
    endfunction

    function automatic logic [127:0] all_ctl();
        return 128'({strobes(), bus.arb_mem_wr, bus.arb_mem_size, bus.arb_mem_addr, bus.arb_mem_wdata});
    endfunction

    function automatic logic [127:0] all_rdata();
        return 128'({bus.mem_icache_rdata, bus.mem_dcache_rdata});
    endfunction

    function automatic logic [127:0] fields();
        return 128'({bus.arb_mem_wr, bus.arb_mem_size, bus.arb_mem_addr});
    endfunction

    // Transaction-level reference state for the random phase
    bit          m_busy, m_acc, m_own, m_wr, m_last;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;

    initial begin
        bit rr_mode;
        int n_rounds;
        bit order [3];
`ifdef L1_ARB_RR_EN
        rr_mode = 1'b1;
`else
        rr_mode = 1'b0;
`endif

        // Reset state
        rst = 1'b1;
        clr_in();
        next_cyc();
        at_neg();
        chk("reset_ctl", all_ctl(), 128'(0));
        chk("reset_rdata", all_rdata(), 128'(0));
        next_cyc();
        rst = 1'b0;

        // Icache-only read: req cycle 0, addrOK cycle 2, dataOK cycle 5
        bus.icache_mem_req  = 1'b1;
        bus.icache_mem_addr = 32'h1C00_0040;
        bus.icache_mem_size = 2'd2;
        at_neg(); chk("t1_c0", 128'(strobes()), 128'(5'b00000));
        next_cyc();
        at_neg(); chk("t1_c1", 128'(strobes()), 128'(5'b10000));
        chk("t1_c1_fields", fields(), 128'({1'b0, 2'd2, 32'h1C00_0040}));
        next_cyc();
        bus.mem_arb_addrOK = 1'b1;
        at_neg(); chk("t1_c2_addrok", 128'(strobes()), 128'(5'b11000));
        next_cyc();
        bus.mem_arb_addrOK = 1'b0;
        bus.icache_mem_req = 1'b0;
        at_neg(); chk("t1_c3", 128'(strobes()), 128'(5'b00000));
        next_cyc();
        at_neg(); chk("t1_c4", 128'(strobes()), 128'(5'b00000));
        chk("t1_c4_stable", fields(), 128'({1'b0, 2'd2, 32'h1C00_0040}));
        next_cyc();
        bus.mem_arb_dataOK = 1'b1;
        bus.mem_arb_rdata  = 32'hDEAD_BEEF;
        at_neg(); chk("t1_c5_dataok", 128'(strobes()), 128'(5'b00100));
        chk("t1_c5_rdata", 128'(bus.mem_icache_rdata), 128'(32'hDEAD_BEEF));
        next_cyc();

        // Dcache write raised in cycle 6: capture there proves the arbiter is back in IDLE
        bus.mem_arb_dataOK   = 1'b0;
        bus.mem_arb_rdata    = '0;
        bus.dcache_mem_req   = 1'b1;
        bus.dcache_mem_wr    = 1'b1;
        bus.dcache_mem_addr  = 32'h0000_0100;
        bus.dcache_mem_size  = 2'd2;
        bus.dcache_mem_wdata = 32'h1234_5678;
        at_neg(); chk("t2_c6", 128'(strobes()), 128'(5'b00000));
        next_cyc();
        bus.mem_arb_addrOK = 1'b1;
        bus.mem_arb_dataOK = 1'b1;
        at_neg(); chk("t2_c7_both", 128'(strobes()), 128'(5'b10011));
        chk("t2_c7_fields", fields(), 128'({1'b1, 2'd2, 32'h0000_0100}));
        chk("t2_c7_wdata", 128'(bus.arb_mem_wdata), 128'(32'h1234_5678));
        next_cyc();
        clr_in();
        bus.mem_arb_dataOK = 1'b1;
        at_neg(); chk("t2_c8_no_wait", 128'(strobes()), 128'(5'b00000));
        next_cyc();
        bus.mem_arb_dataOK = 1'b0;

        // Simultaneous requests from a fresh reset
        do_reset();
        if (rr_mode) begin
            n_rounds = 3; order[0] = 1'b0; order[1] = 1'b1; order[2] = 1'b0;
        end else begin
            n_rounds = 2; order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b0;
        end
        bus.icache_mem_req  = 1'b1;
        bus.icache_mem_addr = 32'h0000_2000;
        bus.icache_mem_size = 2'd2;
        bus.dcache_mem_req  = 1'b1;
        bus.dcache_mem_addr = 32'h0000_3000;
        bus.dcache_mem_size = 2'd1;
        at_neg(); chk("t3_idle", 128'(strobes()), 128'(5'b00000));
        next_cyc();
        for (int r = 0; r < n_rounds; r++) begin
            bus.mem_arb_addrOK = 1'b1;
            bus.mem_arb_dataOK = 1'b1;
            at_neg();
            chk($sformatf("t3_r%0d_grant", r), 128'(strobes()),
                128'(order[r] ? 5'b10011 : 5'b11100));
            chk($sformatf("t3_r%0d_addr", r), 128'(bus.arb_mem_addr),
                128'(order[r] ? 32'h0000_3000 : 32'h0000_2000));
            next_cyc();
            bus.mem_arb_addrOK = 1'b0;
            bus.mem_arb_dataOK = 1'b0;
            if (!rr_mode) begin
                if (order[r]) bus.dcache_mem_req = 1'b0;
                else          bus.icache_mem_req = 1'b0;
            end
            at_neg(); chk($sformatf("t3_r%0d_turn", r), 128'(strobes()), 128'(5'b00000));
            next_cyc();
        end

        // Reset during WAIT_DATA, late dataOK right after release
        do_reset();
        bus.icache_mem_req  = 1'b1;
        bus.icache_mem_addr = 32'h0000_0044;
        next_cyc();
        bus.mem_arb_addrOK = 1'b1;
        next_cyc();
        bus.mem_arb_addrOK = 1'b0;
        bus.icache_mem_req = 1'b0;
        at_neg(); chk("t4_wait", 128'(strobes()), 128'(5'b00000));
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        bus.mem_arb_dataOK = 1'b1;
        at_neg(); chk("t4_post_ctl", all_ctl(), 128'(0));
        chk("t4_post_rdata", all_rdata(), 128'(0));
        next_cyc();
        bus.mem_arb_dataOK = 1'b0;
        at_neg(); chk("t4_post2", all_ctl(), 128'(0));
        next_cyc();

        // Stray strobes in IDLE
        bus.mem_arb_addrOK = 1'b1;
        bus.mem_arb_dataOK = 1'b1;
        at_neg(); chk("t5_stray0", 128'(strobes()), 128'(5'b00000));
        next_cyc();
        at_neg(); chk("t5_stray1", 128'(strobes()), 128'(5'b00000));
        next_cyc();
        bus.mem_arb_addrOK = 1'b0;
        bus.mem_arb_dataOK = 1'b0;
        bus.icache_mem_req = 1'b1;
        bus.icache_mem_addr = 32'h0000_0500;
        next_cyc();
        at_neg(); chk("t5_still_idle", 128'(strobes()), 128'(5'b10000));
        next_cyc();

        // Randomized traffic against the transaction model
        do_reset();
        m_busy = 1'b0; m_acc = 1'b0; m_own = 1'b0; m_last = 1'b1;
        m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_size = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit e_req, e_a, e_d, pick_d;
            if (!bus.icache_mem_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.icache_mem_req  = 1'b1;
                    bus.icache_mem_addr = $urandom;
                    bus.icache_mem_size = 2'($urandom_range(0, 2));
                end
            end else if ($urandom_range(0, 15) == 0) bus.icache_mem_req = 1'b0;
            if (!bus.dcache_mem_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.dcache_mem_req   = 1'b1;
                    bus.dcache_mem_wr    = 1'($urandom_range(0, 1));
                    bus.dcache_mem_addr  = $urandom;
                    bus.dcache_mem_size  = 2'($urandom_range(0, 2));
                    bus.dcache_mem_wdata = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) bus.dcache_mem_req = 1'b0;
            bus.mem_arb_addrOK = ($urandom_range(0, 2) == 0);
            bus.mem_arb_dataOK = ($urandom_range(0, 2) == 0);
            bus.mem_arb_rdata  = $urandom;

            e_req = m_busy && !m_acc;
            e_a   = e_req && bus.mem_arb_addrOK;
            e_d   = m_busy && bus.mem_arb_dataOK && (m_acc || bus.mem_arb_addrOK);
            at_neg();
            chk("rnd_strobes", 128'(strobes()),
                128'({e_req, e_a && !m_own, e_d && !m_own, e_a && m_own, e_d && m_own}));
            if (m_busy) begin
                chk("rnd_fields", fields(), 128'({m_wr, m_size, m_addr}));
                if (m_wr) chk("rnd_wdata", 128'(bus.arb_mem_wdata), 128'(m_wdata));
            end
            if (e_d)
                chk("rnd_rdata", 128'(m_own ? bus.mem_dcache_rdata : bus.mem_icache_rdata),
                    128'(bus.mem_arb_rdata));

            if (!m_busy) begin
                if (bus.icache_mem_req || bus.dcache_mem_req) begin
                    if (bus.icache_mem_req && bus.dcache_mem_req) pick_d = rr_mode ? !m_last : 1'b1;
                    else pick_d = bus.dcache_mem_req;
                    m_busy  = 1'b1;
                    m_acc   = 1'b0;
                    m_own   = pick_d;
                    m_last  = pick_d;
                    m_wr    = pick_d && bus.dcache_mem_wr;
                    m_addr  = pick_d ? bus.dcache_mem_addr : bus.icache_mem_addr;
                    m_size  = pick_d ? bus.dcache_mem_size : bus.icache_mem_size;
                    m_wdata = bus.dcache_mem_wdata;
                end
            end else if (e_d) m_busy = 1'b0;
            else if (e_a) m_acc = 1'b1;

            next_cyc();
            if (e_a) begin
                if (m_own) bus.dcache_mem_req = 1'b0;
                else       bus.icache_mem_req = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
